// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: initiator side of the registered 3-bit ALU interface.
// It takes one host command at a time, drives the ALU from held registers,
// waits ALU_LATENCY edges, then captures the ALU result into a response
// register that is returned over a valid/ready handshake.
// Optional build macro: ALU_SEQ_STATS_EN adds saturating command and
// invalid-response counters (stat_cmds, stat_invalid).
module alu_cmd_sequencer #(
   parameter int ALU_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_a,
   input  logic [2:0]  cmd_b,
   input  logic [2:0]  cmd_opcode,
   input  logic [6:0]  cmd_ctrl,
   output logic [2:0]  A,
   output logic [2:0]  B,
   output logic [2:0]  opcode,
   output logic        cin,
   output logic        serial_in,
   output logic        direction,
   output logic        red_op_A,
   output logic        red_op_B,
   output logic        bypass_A,
   output logic        bypass_B,
   input  logic [5:0]  alu_out,
   input  logic [15:0] alu_leds,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [5:0]  rsp_out,
   output logic        rsp_invalid
`ifdef ALU_SEQ_STATS_EN
   ,
   output logic [15:0] stat_cmds,
   output logic [15:0] stat_invalid
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] LAT = 4'(ALU_LATENCY);

   // The wait counter is 4 bits wide, so only latencies 1..15 are representable.
   if ((ALU_LATENCY < 1) || (ALU_LATENCY > 15)) begin : g_bad_latency
      $error("alu_cmd_sequencer: ALU_LATENCY must be in 1..15");
   end

   state_t     state_r;
   logic [3:0] cnt_r;
   logic       accept_s;
   logic       rsp_hs_s;

   assign cmd_ready = (state_r == ST_IDLE);
   assign accept_s  = cmd_valid & cmd_ready;
   assign rsp_hs_s  = rsp_valid & rsp_ready;

   // Command/response FSM; ALU-facing registers change only on accept so
   // shift/rotate history in the ALU is never disturbed while idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 4'd0;
         A           <= 3'd0;
         B           <= 3'd0;
         opcode      <= 3'd0;
         cin         <= 1'b0;
         serial_in   <= 1'b0;
         direction   <= 1'b0;
         red_op_A    <= 1'b0;
         red_op_B    <= 1'b0;
         bypass_A    <= 1'b0;
         bypass_B    <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_out     <= 6'd0;
         rsp_invalid <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  A         <= cmd_a;
                  B         <= cmd_b;
                  opcode    <= cmd_opcode;
                  cin       <= cmd_ctrl[0];
                  serial_in <= cmd_ctrl[1];
                  direction <= cmd_ctrl[2];
                  red_op_A  <= cmd_ctrl[3];
                  red_op_B  <= cmd_ctrl[4];
                  bypass_A  <= cmd_ctrl[5];
                  bypass_B  <= cmd_ctrl[6];
                  cnt_r     <= LAT;
                  state_r   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               cnt_r <= cnt_r - 4'd1;
               if (cnt_r == 4'd1) begin
                  rsp_out     <= alu_out;
                  rsp_invalid <= |alu_leds;
                  rsp_valid   <= 1'b1;
                  state_r     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_hs_s) begin
                  rsp_valid <= 1'b0;
                  state_r   <= ST_IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               cnt_r     <= 4'd0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef ALU_SEQ_STATS_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : (v + 16'd1);
   endfunction

   // Saturating counts of accepted commands and of invalid responses handed back.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_cmds    <= 16'd0;
         stat_invalid <= 16'd0;
      end else begin
         if (accept_s) begin
            stat_cmds <= sat_inc(stat_cmds);
         end
         if (rsp_hs_s && rsp_invalid) begin
            stat_invalid <= sat_inc(stat_invalid);
         end
      end
   end
`endif

endmodule
